// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO stream reader.
// Buffer depth and the read-credit rule live here.
package fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;
  localparam int BUF_DEPTH  = 2;

  typedef logic [1:0] occ_t;

  // True when one more read still fits once inflight data lands.
  function automatic logic credit_ok(
    input occ_t occ,
    input logic infl,
    input logic pop
  );
    logic [2:0] sum;
    sum = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
    return sum < 3'(BUF_DEPTH);
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry output buffer between the FIFO read port and the stream.
// Head stays put until popped; captures into a full buffer are dropped.
module rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output occ_t              occ,
  output logic              ovf
);

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              full;
  logic              accept;

  assign full   = (occ == 2'(BUF_DEPTH));
  assign accept = capture & (~full | pop);
  assign ovf    = capture & full & ~pop;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= cap_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({accept, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Pulls bytes from a synchronous FIFO and replays them as a valid/ready stream.
// Reads are credit-limited so the two-entry buffer never overflows.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              buf_empty,
  input  logic [DATA_W-1:0] buf_out,
  output logic              rd_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  byte_cnt,
  output logic              ovf_err
);

  logic inflight;
  logic pop;
  logic ovf_hit;
  occ_t occ;

  rd_skid_buf #(
    .DATA_W(DATA_W)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .capture (inflight),
    .cap_data(buf_out),
    .pop     (pop),
    .head    (m_data),
    .occ     (occ),
    .ovf     (ovf_hit)
  );

  assign m_valid = (occ != '0);
  assign pop     = m_valid & m_ready;

  // Held low while reset is asserted so the FIFO is never popped then.
  assign rd_en = rst_n & en & ~buf_empty
               & credit_ok(occ, inflight, pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      byte_cnt <= '0;
      ovf_err  <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (pop) begin
        byte_cnt <= byte_cnt + CNT_W'(1);
      end
      if (ovf_hit) begin
        ovf_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: queue-based FIFO and buffer model,
// per-cycle compare plus directed literal checks.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          buf_empty = 1'b1;
  logic [DW-1:0] buf_out = '0;
  logic          m_ready = 1'b0;
  logic          rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic [CW-1:0] byte_cnt;
  logic          ovf_err;

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .DATA_W(DW),
    .CNT_W (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .buf_empty(buf_empty),
    .buf_out  (buf_out),
    .rd_en    (rd_en),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .byte_cnt (byte_cnt),
    .ovf_err  (ovf_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] buf_q [$];
  logic [DW-1:0] sent_q [$];
  bit            infl_m;
  logic [DW-1:0] infl_d;
  logic [CW-1:0] cnt_m;
  bit            ovf_m;
  bit            exp_pop;
  bit            rd_s;
  int            rd_pulses;
  int            pops;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [DW-1:0] b);
    fifo_q.push_back(b);
    sent_q.push_back(b);
  endtask

  task automatic at_neg();
    bit exp_rd;
    int room;
    buf_empty = (fifo_q.size() == 0);
    @(negedge clk);
    exp_pop = (buf_q.size() != 0) && m_ready;
    room = buf_q.size() + int'(infl_m) - int'(exp_pop);
    exp_rd = rst_n && en && (fifo_q.size() != 0) && (room < 2);
    check("rd_en", 32'(rd_en), 32'(exp_rd));
    check("m_valid", 32'(m_valid), 32'(buf_q.size() != 0));
    if (buf_q.size() != 0) check("m_data", 32'(m_data), 32'(buf_q[0]));
    if (exp_pop && sent_q.size() != 0)
      check("order", 32'(m_data), 32'(sent_q[0]));
    check("byte_cnt", 32'(byte_cnt), 32'(cnt_m));
    check("ovf_err", 32'(ovf_err), 32'(ovf_m));
    rd_s = (rd_en === 1'b1);
    if (rd_s) rd_pulses++;
  endtask

  task automatic at_pos();
    @(posedge clk);
    #1;
    if (exp_pop) begin
      void'(buf_q.pop_front());
      if (sent_q.size() != 0) void'(sent_q.pop_front());
      cnt_m++;
      pops++;
    end
    if (infl_m) begin
      if (buf_q.size() < 2) buf_q.push_back(infl_d);
      else ovf_m = 1'b1;
    end
    infl_m = rd_s;
    if (rd_s && fifo_q.size() != 0) begin
      infl_d = fifo_q.pop_front();
      buf_out = infl_d;
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      at_neg();
      at_pos();
    end
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_byte_cnt", 32'(byte_cnt), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_ovf", 32'(ovf_err), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    fifo_q.delete();
    buf_q.delete();
    sent_q.delete();
    infl_m = 1'b0;
    cnt_m = '0;
    ovf_m = 1'b0;
    exp_pop = 1'b0;
    rd_s = 1'b0;
    buf_out = '0;
    buf_empty = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] t1_exp [3];
    int guard;
    t1_exp = '{8'h11, 8'h22, 8'h33};
    cnt_m = '0;
    do_reset();

    // Three-byte stream at full rate.
    push(8'h11); push(8'h22); push(8'h33);
    en = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      at_neg();
      if (c == 0) check("t1_rd_c0", 32'(rd_en), 32'd1);
      if (c == 1) check("t1_valid_c1", 32'(m_valid), 32'd0);
      if (c >= 2 && c <= 4) begin
        check("t1_valid", 32'(m_valid), 32'd1);
        check("t1_data", 32'(m_data), 32'(t1_exp[c-2]));
      end
      at_pos();
    end
    at_neg();
    check("t1_cnt", 32'(byte_cnt), 32'd3);
    at_pos();

    // Backpressure: only two reads, head held.
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    rd_pulses = 0;
    cycles(8);
    at_neg();
    check("t2_pulses", 32'(rd_pulses), 32'd2);
    check("t2_valid", 32'(m_valid), 32'd1);
    check("t2_head", 32'(m_data), 32'hA0);
    at_pos();
    m_ready = 1'b1;
    pops = 0;
    guard = 0;
    while (pops < 5 && guard < 40) begin
      at_neg();
      at_pos();
      guard++;
    end
    check("t2_delivered", 32'(pops), 32'd5);
    check("t2_ovf", 32'(ovf_err), 32'd0);

    // Ready toggling every cycle.
    for (int i = 0; i < 10; i++) push(8'h40 + 8'(i));
    for (int i = 0; i < 40; i++) begin
      m_ready = ~m_ready;
      at_neg();
      at_pos();
    end
    m_ready = 1'b1;
    cycles(3);
    at_neg();
    check("t3_cnt", 32'(byte_cnt), 32'd18);
    at_pos();

    // Enable dropped right after one read.
    en = 1'b0;
    push(8'hC0); push(8'hC1); push(8'hC2);
    cycles(1);
    en = 1'b1;
    rd_pulses = 0;
    at_neg();
    check("t4_rd", 32'(rd_en), 32'd1);
    at_pos();
    en = 1'b0;
    cycles(6);
    at_neg();
    check("t4_pulses", 32'(rd_pulses), 32'd1);
    check("t4_cnt", 32'(byte_cnt), 32'd19);
    at_pos();
    en = 1'b1;
    cycles(6);
    at_neg();
    check("t4_drain", 32'(byte_cnt), 32'd21);
    at_pos();

    // Reset while data is buffered and inflight.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'hE0 + 8'(i));
    cycles(2);
    at_neg();
    do_reset();
    m_ready = 1'b1;
    push(8'h01); push(8'h02); push(8'h03);
    cycles(8);
    at_neg();
    check("t5_cnt", 32'(byte_cnt), 32'd3);
    at_pos();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) < 8);
      m_ready = ($urandom_range(0, 9) < 6);
      if (fifo_q.size() < 6) begin
        for (int k = 0; k < int'($urandom_range(0, 2)); k++)
          push(8'($urandom));
      end
      at_neg();
      at_pos();
    end
    en = 1'b1;
    m_ready = 1'b1;
    guard = 0;
    while ((buf_q.size() != 0 || fifo_q.size() != 0 || infl_m)
           && guard < 100) begin
      at_neg();
      at_pos();
      guard++;
    end
    check("rand_drained", 32'(buf_q.size() + fifo_q.size()), 32'd0);

    // Counter wrap.
    do_reset();
    guard = 0;
    while (cnt_m != 16'hFFFF && guard < 70000) begin
      if (fifo_q.size() < 4) push(8'($urandom));
      at_neg();
      at_pos();
      guard++;
    end
    check("wrap_reach", 32'(cnt_m), 32'hFFFF);
    if (fifo_q.size() < 4) push(8'($urandom));
    at_neg();
    check("wrap_ffff", 32'(byte_cnt), 32'hFFFF);
    check("wrap_valid", 32'(m_valid), 32'd1);
    at_pos();
    if (fifo_q.size() < 4) push(8'($urandom));
    at_neg();
    check("wrap_0000", 32'(byte_cnt), 32'h0000);
    at_pos();
    if (fifo_q.size() < 4) push(8'($urandom));
    at_neg();
    check("wrap_0001", 32'(byte_cnt), 32'h0001);
    at_pos();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
